// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared FSM state type and lane-count helper for the byte-lane RAM.
// Revision : 1.0
// ============================================================================
package ram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int c_min_dw = 8;

    function automatic int lane_count(input int dw);
        return dw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sp_be_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_be_core
// Brief    : Single-port RAM, 1-cycle registered read, per-byte-lane write enable.
// Revision : 1.0
// ============================================================================
module ram_sp_be_core
    import ram_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    localparam int c_lanes = lane_count(DW);
    localparam int c_depth = 1 << AW;

    // Each lane is an independent byte-wide array so a write never touches
    // disabled lanes and the read port holds its value across writes.
    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
        logic [7:0] r_mem [c_depth];
        logic [7:0] r_rd;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[i]) begin
                        r_mem[addr] <= wdata[8*i +: 8];
                    end
                end else begin
                    r_rd <= r_mem[addr];
                end
            end
        end

        assign rdata[8*i +: 8] = r_rd;
    end

endmodule
`default_nettype wire

// File: rtl/ram_bytelane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_bytelane_ctrl
// Brief    : Byte-lane RAM controller with optional zero-fill sweep after reset
//            and optional output pipeline register.
// Revision : 1.0
// ============================================================================
module ram_bytelane_ctrl
    import ram_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 10,
    parameter int OUT_REG   = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            wren,
    input  logic [AW-1:0]   addr,
    input  logic [DW/8-1:0] ben,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    output logic            init_done
);

    localparam int c_lanes = lane_count(DW);

    if ((DW % 8 != 0) || (DW < c_min_dw)) begin : g_dw_check
        $error("ram_bytelane_ctrl: DW must be a multiple of 8 and at least 8");
    end

    ram_state_e          r_state;
    logic [AW-1:0]       r_init_cnt;
    logic                r_init_done;
    logic                r_rd_v1;

    logic                w_accept;
    logic                w_rd_accept;
    logic                w_mem_en;
    logic                w_mem_we;
    logic [c_lanes-1:0]  w_mem_be;
    logic [AW-1:0]       w_mem_addr;
    logic [DW-1:0]       w_mem_wdata;
    logic [DW-1:0]       w_mem_rdata;

    assign req_ready   = r_init_done;
    assign init_done   = r_init_done;
    assign w_accept    = req_valid && r_init_done;
    assign w_rd_accept = w_accept && !wren;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= (INIT_ZERO != 0) ? INIT : READY;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + AW'(1);
                    if (&r_init_cnt) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    // The sweep owns the array port while in INIT; held off during rst so
    // reset alone never modifies stored data.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_addr  = addr;
        w_mem_wdata = din;
        if ((r_state == INIT) && !rst) begin
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_be    = '1;
            w_mem_addr  = r_init_cnt;
            w_mem_wdata = '0;
        end else if (w_accept) begin
            w_mem_en    = 1'b1;
            w_mem_we    = wren;
            w_mem_be    = ben;
        end
    end

    ram_sp_be_core #(
        .DW (DW),
        .AW (AW)
    ) u_core (
        .clk   (clk),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .be    (w_mem_be),
        .addr  (w_mem_addr),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v1 <= 1'b0;
        end else begin
            r_rd_v1 <= w_rd_accept;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] r_dout;
        logic          r_rd_v2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout  <= '0;
                r_rd_v2 <= 1'b0;
            end else begin
                r_rd_v2 <= r_rd_v1;
                if (r_rd_v1) begin
                    r_dout <= w_mem_rdata;
                end
            end
        end

        assign dout       = r_dout;
        assign dout_valid = r_rd_v2;
    end else begin : g_no_out_reg
        // The core read register holds across writes; mask it to zero until
        // the first read after reset so dout starts clean.
        logic r_have_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_have_data <= 1'b0;
            end else if (w_rd_accept) begin
                r_have_data <= 1'b1;
            end
        end

        assign dout       = r_have_data ? w_mem_rdata : '0;
        assign dout_valid = r_rd_v1;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_bytelane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bytelane_ctrl
// Brief    : Directed bench for ram_bytelane_ctrl; three instances share stimulus
//            (OUT_REG=0, OUT_REG=1, and INIT_ZERO=0).
// Revision : 1.0
// ============================================================================
module tb_ram_bytelane_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          wren = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [3:0]    ben = '0;
    logic [31:0]   din = '0;

    logic [31:0]   dout0, dout1, dout2;
    logic          dv0, dv1, dv2;
    logic          rdy0, rdy1, rdy2;
    logic          id0, id1, id2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_bytelane_ctrl #(.DW(DW), .AW(AW), .OUT_REG(0), .INIT_ZERO(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .wren(wren),
        .addr(addr), .ben(ben), .din(din), .dout(dout0), .dout_valid(dv0), .init_done(id0)
    );

    ram_bytelane_ctrl #(.DW(DW), .AW(AW), .OUT_REG(1), .INIT_ZERO(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .wren(wren),
        .addr(addr), .ben(ben), .din(din), .dout(dout1), .dout_valid(dv1), .init_done(id1)
    );

    ram_bytelane_ctrl #(.DW(DW), .AW(AW), .OUT_REG(0), .INIT_ZERO(0)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .wren(wren),
        .addr(addr), .ben(ben), .din(din), .dout(dout2), .dout_valid(dv2), .init_done(id2)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; one-cycle write request.
    task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        req_valid = 1'b1; wren = 1'b1; addr = a; ben = b; din = d;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check1("wr_no_dv", dv0, 1'b0);
    endtask

    // Called at a negedge; one-cycle read, result checked on the OUT_REG=0 instance.
    task automatic rd0(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [31:0] exp);
        req_valid = 1'b1; wren = 1'b0; addr = a; ben = b;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check1({tag, "_dv"}, dv0, 1'b1);
        check32(tag, dout0, exp);
    endtask

    initial begin
        int  cyc;
        bit  saw_dv;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_dout", dout0, 32'd0);
        check1("rst_dv", dv0, 1'b0);
        check1("rst_init_done", id0, 1'b0);
        check1("rst_ready", rdy0, 1'b0);
        check32("rst_dout_oreg", dout1, 32'd0);
        check1("rst_dv_oreg", dv1, 1'b0);

        // Release with a write request pending through INIT.
        req_valid = 1'b1; wren = 1'b1; addr = 4'd9; ben = 4'hF; din = 32'hFFFF_FFFF;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check1("noinit_done_first_cycle", id2, 1'b1);
        repeat (6) begin @(posedge clk); @(negedge clk); end
        check1("mid_init_not_done", id0, 1'b0);

        // Reset pulse at INIT count 7.
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check1("rst_pulse_ready_low", rdy0, 1'b0);
        rst = 1'b0;
        cyc = 0; saw_dv = 1'b0;
        while (!id0 && cyc < 40) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (dv0 || dv1) saw_dv = 1'b1;
        end
        req_valid = 1'b0;
        check32("init_restart_cycles", 32'(cyc), 32'd16);
        check1("init_no_dv", saw_dv, 1'b0);
        check1("init_done_oreg", id1, 1'b1);
        check1("ready_eq_init_done", rdy0, 1'b1);

        for (int i = 0; i < 16; i++) rd0("sweep_zero", 4'(i), 4'hF, 32'd0);

        // Full write then single-lane overwrite, read right after.
        wr(4'd5, 4'hF, 32'hDEAD_BEEF);
        wr(4'd5, 4'h1, 32'h0000_0011);
        rd0("merge_lane0", 4'd5, 4'hF, 32'hDEAD_BE11);
        @(negedge clk);
        check1("dv_one_cycle", dv0, 1'b0);
        check32("dout_hold_idle", dout0, 32'hDEAD_BE11);
        wr(4'd7, 4'hF, 32'h1234_5678);
        check32("wr_keeps_dout", dout0, 32'hDEAD_BE11);

        wr(4'd3, 4'h5, 32'hAABB_CCDD);
        rd0("ben0101_ben0_read", 4'd3, 4'h0, 32'h00BB_00DD);

        wr(4'd10, 4'hF, 32'h1122_3344);
        wr(4'd10, 4'hA, 32'hAABB_CCDD);
        rd0("ben1010", 4'd10, 4'hF, 32'hAA22_CC44);
        wr(4'd10, 4'h0, 32'hFFFF_FFFF);
        rd0("ben0000_no_change", 4'd10, 4'hF, 32'hAA22_CC44);
        rd0("addr7_full", 4'd7, 4'h3, 32'h1234_5678);

        // Back-to-back reads on both output configurations.
        wr(4'd0, 4'hF, 32'hA0A0_A0A0);
        wr(4'd1, 4'hF, 32'hB1B1_B1B1);
        wr(4'd2, 4'hF, 32'hC2C2_C2C2);
        req_valid = 1'b1; wren = 1'b0; ben = 4'hF; addr = 4'd0;
        @(posedge clk); @(negedge clk);
        addr = 4'd1;
        check1("oreg_c1_dv", dv1, 1'b0);
        check32("b2b_r0", dout0, 32'hA0A0_A0A0);
        @(posedge clk); @(negedge clk);
        addr = 4'd2;
        check1("oreg_c2_dv", dv1, 1'b1);
        check32("oreg_c2_data", dout1, 32'hA0A0_A0A0);
        check32("b2b_r1", dout0, 32'hB1B1_B1B1);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check1("oreg_c3_dv", dv1, 1'b1);
        check32("oreg_c3_data", dout1, 32'hB1B1_B1B1);
        check32("b2b_r2", dout0, 32'hC2C2_C2C2);
        @(posedge clk); @(negedge clk);
        check1("oreg_c4_dv", dv1, 1'b1);
        check32("oreg_c4_data", dout1, 32'hC2C2_C2C2);
        @(posedge clk); @(negedge clk);
        check1("oreg_c5_dv", dv1, 1'b0);
        check32("oreg_hold", dout1, 32'hC2C2_C2C2);

        // Reset while an OUT_REG=1 read is in flight.
        req_valid = 1'b1; wren = 1'b0; addr = 4'd1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check1("squash_dv_oreg", dv1, 1'b0);
        check32("squash_dout_oreg", dout1, 32'd0);
        check32("rst_dout_again", dout0, 32'd0);
        rst = 1'b0;
        cyc = 0;
        @(posedge clk); cyc++; @(negedge clk);
        check1("noinit_ready_after_rst", id2, 1'b1);
        check1("init_busy_after_rst", id0, 1'b0);
        req_valid = 1'b1; wren = 1'b0; ben = 4'hF; addr = 4'd10;
        @(posedge clk); cyc++; @(negedge clk);
        req_valid = 1'b0;
        check1("noinit_read_dv", dv2, 1'b1);
        check32("array_survives_rst", dout2, 32'hAA22_CC44);
        check1("init_ignores_req", dv0, 1'b0);
        while (!id0 && cyc < 40) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        check32("init_second_cycles", 32'(cyc), 32'd16);
        rd0("sweep_cleared", 4'd10, 4'hF, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_bytelane_ctrl.md
RAM_BYTELANE_CTRL -- requirements
Module: ram_bytelane_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width in bits, a multiple of 8 with a minimum of 8.
REQ-002 The block SHALL have parameter AW, default 10, meaning address width; depth is 2^AW words.
REQ-003 The block SHALL have parameter OUT_REG, default 0, meaning 1 adds an output pipeline register.
REQ-004 The block SHALL have parameter INIT_ZERO, default 1, meaning 1 zero-fills the whole array after reset.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, width 1, synchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, width 1, a request is present.
REQ-008 The block SHALL have port req_ready, output, width 1, the block can accept a request.
REQ-009 The block SHALL have port wren, input, width 1, where 1 means write and 0 means read.
REQ-010 The block SHALL have port addr, input, width AW, the word address.
REQ-011 The block SHALL have port ben, input, width DW/8, byte-lane enables; ben[i] covers din[8i+7:8i].
REQ-012 The block SHALL have port din, input, width DW, write data.
REQ-013 The block SHALL have port dout, output, width DW, read data.
REQ-014 The block SHALL have port dout_valid, output, width 1, a one-cycle pulse marking new dout.
REQ-015 The block SHALL have port init_done, output, width 1, high once the array is usable.

Function
REQ-016 A request SHALL be accepted on a cycle where req_valid=1 and req_ready=1; req_ready SHALL equal init_done.
REQ-017 An accepted write SHALL update exactly the lanes with ben[i]=1, for any of the 2^(DW/8) patterns; ben=0 SHALL leave the array unchanged.
REQ-018 A write SHALL NOT change dout and SHALL NOT pulse dout_valid.
REQ-019 An accepted read SHALL return all DW bits regardless of ben (ben ignored on reads); dout_valid SHALL pulse 1 cycle after acceptance when OUT_REG=0, or 2 cycles after when OUT_REG=1.
REQ-020 dout SHALL hold the last read data until the next read result is presented.
REQ-021 A read accepted the cycle after a write to the same address SHALL return the newly written lanes merged with the old unwritten lanes.
REQ-022 Back-to-back reads, one per cycle, SHALL be sustained at full throughput with in-order results for both OUT_REG values.
REQ-023 The FSM SHALL have states INIT and READY; reset enters INIT when INIT_ZERO=1 and READY otherwise.
REQ-024 In INIT, an AW-bit counter SHALL start at 0 and write all-zero with all lanes enabled to one address per cycle.
REQ-025 In INIT, after the write to address 2^AW-1, the FSM SHALL go to READY; init_done SHALL rise on the following cycle, exactly 2^AW cycles after rst deasserts.
REQ-026 In INIT, req_valid SHALL be ignored and no request SHALL be accepted.

Reset
REQ-027 On rst=1, dout SHALL be 0, dout_valid 0, init_done 0, req_ready 0, and the INIT counter 0.
REQ-028 With INIT_ZERO=0, init_done SHALL be 1 on the first cycle after rst deasserts; array contents SHALL be undefined until written.
REQ-029 rst asserted mid-INIT SHALL restart the sweep at address 0 once rst deasserts.
REQ-030 rst asserted mid-read SHALL squash any pending dout_valid.
REQ-031 The array itself SHALL NOT be cleared by rst, apart from the INIT sweep.

Structure
REQ-032 Package ram_pkg SHALL hold the FSM state enum (INIT, READY) and the constant or function giving lane count = DW/8.
REQ-033 The storage SHALL be one sub-module, ram_sp_be_core: a single-port, 1-cycle-read, per-lane write-enable array that vendor macros can replace.
REQ-034 Elaboration SHALL fail when DW is not a multiple of 8.

Verification
REQ-035 Bench: INIT_ZERO=1, AW=4, release rst -> init_done rises 16 cycles later; read of every address returns 0.
REQ-036 Bench: write 0xDEADBEEF with ben=1111 to addr 5, then write 0x00000011 with ben=0001 to addr 5, then read -> dout=0xDEADBE11 and dout_valid 1 cycle after acceptance (OUT_REG=0).
REQ-037 Bench: write 0xAABBCCDD with ben=0101 to a zeroed addr 3, then read -> 0x00BB00DD, ben=0000 on the read still returns the full word.
REQ-038 Bench: OUT_REG=1, reads of addr 0,1,2 in consecutive cycles -> three dout_valid pulses on cycles +2,+3,+4 with the data in order.
REQ-039 Bench: assert rst at INIT count 7, hold 1 cycle -> sweep restarts at 0 and init_done rises 2^AW cycles after release.
REQ-040 Bench: req_valid held high during INIT -> no write lands and no dout_valid pulse until init_done=1.
